// File: rtl/led_key_ctrl.sv
// led_key_ctrl: debounces three active-low push-buttons and emits one-hot
// single-cycle command pulses for the LED sequencer, with optional auto-repeat
// on the speed-up / slow-down keys.
//
// Ports:
//   clk        - single rising-edge clock
//   reset      - asynchronous, active-high reset
//   key_in     - raw buttons, active-low (bit0 speed-up, bit1 slow-down,
//                bit2 speed-restore)
//   key_status - registered one-hot command pulse (one cycle per command)
//   key_busy   - high whenever the FSM is not idle
//   key_cnt    - number of command pulses issued, wraps at 256
module led_key_ctrl #(
  parameter int unsigned DEB_MAX = 20,
  parameter int unsigned REP_MAX = 200,
  parameter bit          REP_EN  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] key_in,
  output logic [2:0] key_status,
  output logic       key_busy,
  output logic [7:0] key_cnt
);

  localparam int unsigned KEY_W = 3;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned KCN_W = 8;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_MAX - 1);
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REP_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DEB  = 2'd1,
    S_HOLD = 2'd2,
    S_REL  = 2'd3
  } state_e;

  logic [KEY_W-1:0] sync1_q, sync2_q;
  logic [KEY_W-1:0] pressed;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [KEY_W-1:0] win_q, win_d;        // winner key, one-hot
  logic [KEY_W-1:0] key_status_q, key_status_d;
  logic             key_busy_q, key_busy_d;
  logic [KCN_W-1:0] key_cnt_q, key_cnt_d;
  logic             win_pressed;
  logic             rep_ok;

  // Two-flop synchronizer; idles high because the keys are active-low
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= key_in;
      sync2_q <= sync1_q;
    end
  end

  assign pressed     = ~sync2_q;
  assign win_pressed = |(pressed & win_q);
  // Restore (bit2) never repeats
  assign rep_ok      = REP_EN && (win_q[0] || win_q[1]);

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      win_q        <= '0;
      key_status_q <= '0;
      key_busy_q   <= 1'b0;
      key_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      win_q        <= win_d;
      key_status_q <= key_status_d;
      key_busy_q   <= key_busy_d;
      key_cnt_q    <= key_cnt_d;
    end
  end

  // Next-state, counter and pulse generation
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    win_d        = win_q;
    key_status_d = '0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (|pressed) begin
          // Lowest index wins on simultaneous presses
          if (pressed[0])      win_d = 3'b001;
          else if (pressed[1]) win_d = 3'b010;
          else                 win_d = 3'b100;
          state_d = S_DEB;
        end
      end
      S_DEB: begin
        if (!win_pressed) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d      = S_HOLD;
          cnt_d        = '0;
          key_status_d = win_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (!win_pressed) begin
          state_d = S_REL;
          cnt_d   = '0;
        end else if (rep_ok && (cnt_q == REP_LAST)) begin
          cnt_d        = '0;
          key_status_d = win_q;
        end else if (cnt_q != CNT_SAT) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_REL: begin
        // Every key must be quiet for a full debounce window
        if (|pressed) begin
          cnt_d = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        win_d   = '0;
      end
    endcase

    key_busy_d = (state_d != S_IDLE);
    key_cnt_d  = key_cnt_q + KCN_W'(|key_status_d);
  end

  assign key_status = key_status_q;
  assign key_busy   = key_busy_q;
  assign key_cnt    = key_cnt_q;

endmodule

// File: tb/tb_led_key_ctrl.sv
// Scoreboard bench for led_key_ctrl: stimulus pushes expected pulses
// (value and cycle), a negedge monitor pops and compares each pulse seen.
module tb_led_key_ctrl;

  logic       clk;
  logic       reset;
  logic [2:0] key_in;
  logic [2:0] key_status;
  logic       key_busy;
  logic [7:0] key_cnt;

  typedef struct packed {
    logic [2:0]  val;
    int unsigned c;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc;
  int          n_pass;
  int          n_total;
  logic [7:0]  exp_cnt;

  led_key_ctrl #(.DEB_MAX(20), .REP_MAX(200), .REP_EN(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .key_in     (key_in),
    .key_status (key_status),
    .key_busy   (key_busy),
    .key_cnt    (key_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
  endtask

  task automatic push_exp(input logic [2:0] val, input int unsigned c);
    exp_t e;
    e.val = val;
    e.c   = c;
    sb.push_back(e);
    exp_cnt = exp_cnt + 8'd1;
  endtask

  // Monitor: every non-zero key_status must match the next expected pulse
  always @(negedge clk) begin
    if (!reset && key_status != 3'b000) begin
      n_total++;
      if (sb.size() == 0) begin
        $display("FAIL pulse_unexpected: got %b expected none at cycle %0d", key_status, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (key_status == e.val && cyc == e.c) n_pass++;
        else $display("FAIL pulse: got %b at cycle %0d expected %b at cycle %0d",
                      key_status, cyc, e.val, e.c);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d", n_pass, n_total);
    $fatal(1);
  end

  initial begin
    int unsigned n;
    n_pass  = 0;
    n_total = 0;
    exp_cnt = 8'd0;
    key_in  = 3'b111;
    reset   = 1'b1;
    step(3);
    check("rst_status", 16'(key_status), 16'd0);
    check("rst_busy",   16'(key_busy),   16'd0);
    check("rst_cnt",    16'(key_cnt),    16'd0);
    reset = 1'b0;
    step(5);

    // Clean press on bit0, released after 40 cycles
    n = cyc;
    key_in = 3'b110;
    push_exp(3'b001, n + 23);
    step(40);
    key_in = 3'b111;
    step(22);
    check("clean_busy_before_idle", 16'(key_busy), 16'd1);
    step(1);
    check("clean_busy_idle", 16'(key_busy), 16'd0);
    check("clean_cnt", 16'(key_cnt), 16'(exp_cnt));

    // Bounce on bit1: three 10-cycle lows, no pulses
    for (int i = 0; i < 3; i++) begin
      key_in = 3'b101;
      step(10);
      key_in = 3'b111;
      step(10);
    end
    step(5);
    check("bounce_busy", 16'(key_busy), 16'd0);
    check("bounce_cnt",  16'(key_cnt),  16'(exp_cnt));

    // Auto-repeat on bit0: four pulses 200 apart
    n = cyc;
    key_in = 3'b110;
    for (int k = 0; k < 4; k++) push_exp(3'b001, n + 23 + 200 * k);
    step(623);
    key_in = 3'b111;
    step(40);
    check("rep0_busy", 16'(key_busy), 16'd0);
    check("rep0_cnt",  16'(key_cnt),  16'(exp_cnt));

    // Restore key held the same time: single pulse only
    n = cyc;
    key_in = 3'b011;
    push_exp(3'b100, n + 23);
    step(623);
    key_in = 3'b111;
    step(40);
    check("rep2_busy", 16'(key_busy), 16'd0);
    check("rep2_cnt",  16'(key_cnt),  16'(exp_cnt));

    // Simultaneous press: bit0 wins; other keys keep FSM in release
    n = cyc;
    key_in = 3'b000;
    push_exp(3'b001, n + 23);
    push_exp(3'b001, n + 223);
    step(300);
    key_in = 3'b001;
    step(100);
    check("simul_held_rel", 16'(key_busy), 16'd1);
    check("simul_cnt", 16'(key_cnt), 16'(exp_cnt));
    key_in = 3'b111;
    step(30);
    check("simul_idle", 16'(key_busy), 16'd0);

    // Reset at cycle 15 of debounce, key still held across reset
    key_in = 3'b110;
    step(18);
    reset = 1'b1;
    #1;
    check("rstmid_status", 16'(key_status), 16'd0);
    check("rstmid_busy",   16'(key_busy),   16'd0);
    check("rstmid_cnt",    16'(key_cnt),    16'd0);
    exp_cnt = 8'd0;
    step(3);
    reset = 1'b0;
    n = cyc;
    push_exp(3'b001, n + 23);
    step(40);
    key_in = 3'b111;
    step(30);
    check("rstmid_after_cnt", 16'(key_cnt), 16'(exp_cnt));

    // 256 clean presses: counter wraps back to its starting value
    for (int i = 0; i < 256; i++) begin
      n = cyc;
      key_in = 3'b110;
      push_exp(3'b001, n + 23);
      step(30);
      key_in = 3'b111;
      step(30);
      if (i == 254) check("wrap_zero", 16'(key_cnt), 16'd0);
    end
    check("wrap_final", 16'(key_cnt), 16'(exp_cnt));
    check("wrap_final_val", 16'(key_cnt), 16'd1);

    step(10);
    check("sb_empty", 16'(sb.size()), 16'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/led_key_ctrl.md
LED_KEY_CTRL -- requirements
Module: led_key_ctrl

Interface
REQ-001 The block SHALL expose the following parameters, one per line:
- DEB_MAX, default 20: consecutive stable cycles required to accept a press or a release.
- REP_MAX, default 200: auto-repeat interval in cycles while key0 or key1 is held.
- REP_EN, default 1: 1 enables auto-repeat, 0 disables it.
REQ-002 clk  input  1  single clock; all logic is on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 key_in  input  3  raw push-buttons, active-low: bit0 = speed-up, bit1 = slow-down, bit2 = speed-restore.
REQ-005 key_status  output  3  registered, one-hot, single-cycle command pulse that drives the LED sequencer key_status input.
REQ-006 key_busy  output  1  high whenever the FSM is not in S_IDLE.
REQ-007 key_cnt  output  8  count of command pulses issued; wraps from 255 to 0.

Function
REQ-008 key_in SHALL pass through a 2-flop synchronizer per bit before any other use; pressed[i] = NOT synchronized key_in[i].
REQ-009 The FSM SHALL have exactly four states: S_IDLE, S_DEB, S_HOLD, S_REL. One shared debounce/repeat counter is 16 bits wide.
REQ-010 In S_IDLE with any pressed bit set, the FSM SHALL latch the winner key, clear the counter and go to S_DEB.
- Priority: bit0 > bit1 > bit2.
- Simultaneous presses resolve to the lowest index.
REQ-011 In S_DEB:
- If the winner is released, return to S_IDLE with the counter cleared and no pulse (bounce rejected).
- Otherwise increment the counter; on the edge where the counter equals DEB_MAX-1, go to S_HOLD, clear the counter and assert key_status[winner] for exactly one cycle.
REQ-012 Press latency SHALL be exactly 2 + DEB_MAX + 1 clk cycles, counted from a stable key_in low to key_status high.
REQ-013 In S_HOLD:
- If the winner is released, go to S_REL and clear the counter.
- Else, if REP_EN=1, the winner is bit0 or bit1, and counter == REP_MAX-1, re-assert key_status[winner] for one cycle and clear the counter.
- Else increment the counter.
- Bit2 (restore) SHALL never auto-repeat.
REQ-014 In S_REL, the FSM SHALL return to S_IDLE only after all pressed bits are 0 for DEB_MAX consecutive cycles. Any pressed bit SHALL clear the counter and keep the FSM in S_REL.
REQ-015 Keys other than the winner SHALL be ignored while the FSM is outside S_IDLE. They SHALL NOT preempt the winner or queue a command.
REQ-016 key_status SHALL be all-zero except in pulse cycles, and SHALL never have more than one bit set.
REQ-017 key_cnt SHALL increment by 1 in every cycle in which key_status is non-zero.
REQ-018 Illegal state encodings SHALL recover to S_IDLE on the next clock, with the counter cleared and no pulse.
REQ-019 The counter SHALL saturate rather than wrap if REP_EN=0 while the FSM stays in S_HOLD.

Reset
REQ-020 While reset is high, the block SHALL hold these values:
- Synchronizer flops 3'b111.
- State S_IDLE, counter 0, winner 0.
- key_status 3'b000, key_busy 0, key_cnt 8'd0.
REQ-021 Reset asserted mid-operation SHALL take effect immediately (asynchronously) and abort any pending pulse.
REQ-022 After reset deasserts, a key already held low SHALL be treated as a new press and go through the full debounce.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
- Clean press: DEB_MAX=20; hold key_in=3'b110 for 40 cycles, then release -> key_status=3'b001 for exactly 1 cycle, 23 cycles after the press; key_cnt=1; key_busy returns to 0 20 cycles after release is synchronized.
- Bounce: key_in bit1 low for 10 cycles, then high, 3 times -> key_status never non-zero; key_cnt=0; FSM back in S_IDLE.
- Auto-repeat: REP_MAX=200; hold bit0 for 2 + 20 + 1 + 600 cycles -> 4 pulses of 3'b001, spaced 200 cycles apart. Same hold on bit2 -> exactly 1 pulse of 3'b100.
- Simultaneous press: key_in=3'b000 held -> only 3'b001 pulses. Releasing bit0 while bits 1 and 2 stay low -> no new pulse, FSM held in S_REL.
- Reset mid-debounce: assert reset at cycle 15 of S_DEB -> outputs zero immediately. After release of reset with the key still held -> pulse exactly 23 cycles later.
- key_cnt wrap: 256 clean presses -> key_cnt returns to 0 with no skipped or extra pulse.
